lmi_watchu: RTL and testbench

- Parametrised watchpoint unit for the LMI debug path.
- Samples the core's instruction-fetch and data-access buses through a register stage, then compares each access against NUM_WP programmable address/mask watchpoints.
- Reports hits as registered per-channel flags, saturating hit counters, a sticky break request to the halt logic, and a show-ahead event FIFO read by the debug host.
- Sits between the core pipeline taps and the debug/trace controller.

---
 rtl/lmi_watchu.sv | 174 +++++++++++++++++
 tb/tb_lmi_watchu.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmi_watchu.sv
// Watchpoint unit: samples fetch/data buses (S1), matches NUM_WP address/mask channels, hit pulse at access+2.
// Hits feed saturating counters, a sticky break request and a show-ahead event FIFO (drop + sticky overflow when full).
module lmi_watchu #(
    parameter int NUM_WP     = 4,
    parameter int AW         = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [AW-1:0]          C_IADDR_A,
    input  logic                   C_IREAD_I_N,
    input  logic [AW-1:0]          C_DADDR_E,
    input  logic                   C_DREAD_E,
    input  logic                   C_DWRITE_E,
    input  logic [3:0]             C_DBYEN_E,
    input  logic                   CP0_XCPN_M,
    input  logic                   X_HALT,
    input  logic                   CFG_WE,
    input  logic [2:0]             CFG_SEL,
    input  logic [AW-1:0]          CFG_ADDR,
    input  logic [AW-1:0]          CFG_MASK,
    input  logic [3:0]             CFG_MODE,
    input  logic [3:0]             CFG_BYEN,
    output logic [NUM_WP-1:0]      WP_HIT,
    output logic                   BRK_REQ,
    input  logic                   BRK_ACK,
    input  logic [2:0]             CNT_SEL,
    output logic [CNT_W-1:0]       CNT_OUT,
    output logic                   EV_VALID,
    output logic [NUM_WP+2+AW-1:0] EV_DATA,
    input  logic                   EV_RDY,
    output logic                   EV_OVF,
    input  logic                   OVF_CLR
);
    localparam int EW = NUM_WP + 2 + AW;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [AW-1:0]    cfg_addr [NUM_WP];
    logic [AW-1:0]    cfg_mask [NUM_WP];
    logic [3:0]       cfg_mode [NUM_WP];
    logic [3:0]       cfg_byen [NUM_WP];
    logic [CNT_W-1:0] cnt      [NUM_WP];

    logic          s1_ivld, s1_dvld, s1_rd, s1_wr;
    logic [AW-1:0] s1_iaddr, s1_daddr;
    logic [3:0]    s1_byen;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_ivld  <= 1'b0;
            s1_dvld  <= 1'b0;
            s1_rd    <= 1'b0;
            s1_wr    <= 1'b0;
            s1_iaddr <= '0;
            s1_daddr <= '0;
            s1_byen  <= '0;
        end else if (X_HALT) begin
            s1_ivld <= 1'b0;
            s1_dvld <= 1'b0;
        end else begin
            s1_ivld  <= ~C_IREAD_I_N;
            s1_dvld  <= C_DREAD_E | C_DWRITE_E;
            s1_rd    <= C_DREAD_E;
            s1_wr    <= C_DWRITE_E;
            s1_iaddr <= C_IADDR_A;
            s1_daddr <= C_DADDR_E;
            s1_byen  <= C_DBYEN_E;
        end
    end

    logic [NUM_WP-1:0] ihit, dhit;
    logic              brk_set;

    // The exception in M arrives one cycle after the data access, i.e. while it sits in S1.
    always_comb begin
        ihit    = '0;
        dhit    = '0;
        brk_set = 1'b0;
        for (int k = 0; k < NUM_WP; k++) begin
            ihit[k] = s1_ivld & cfg_mode[k][0]
                    & (((s1_iaddr ^ cfg_addr[k]) & ~cfg_mask[k]) == '0);
            dhit[k] = s1_dvld & ~CP0_XCPN_M
                    & (((s1_daddr ^ cfg_addr[k]) & ~cfg_mask[k]) == '0)
                    & ((s1_byen & cfg_byen[k]) != 4'd0)
                    & ((s1_rd & cfg_mode[k][1]) | (s1_wr & cfg_mode[k][2]));
            brk_set = brk_set | ((ihit[k] | dhit[k]) & cfg_mode[k][3]);
        end
    end

    logic          ev_dhit, ev_ihit;
    logic [AW-1:0] ev_addr;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            WP_HIT  <= '0;
            ev_dhit <= 1'b0;
            ev_ihit <= 1'b0;
            ev_addr <= '0;
            BRK_REQ <= 1'b0;
        end else begin
            WP_HIT  <= ihit | dhit;
            ev_dhit <= |dhit;
            ev_ihit <= |ihit;
            ev_addr <= (|dhit) ? s1_daddr : s1_iaddr;
            BRK_REQ <= brk_set | (BRK_REQ & ~BRK_ACK);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < NUM_WP; k++) begin
                cfg_addr[k] <= '0;
                cfg_mask[k] <= '0;
                cfg_mode[k] <= '0;
                cfg_byen[k] <= '0;
                cnt[k]      <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WP; k++) begin
                if (CFG_WE && CFG_SEL == 3'(k)) begin
                    cfg_addr[k] <= CFG_ADDR;
                    cfg_mask[k] <= CFG_MASK;
                    cfg_mode[k] <= CFG_MODE;
                    cfg_byen[k] <= CFG_BYEN;
                    cnt[k]      <= '0;
                end else if (WP_HIT[k] && cnt[k] != CNT_MAX) begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        CNT_OUT = '0;
        for (int k = 0; k < NUM_WP; k++) begin
            if (CNT_SEL == 3'(k)) CNT_OUT = cnt[k];
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop, full, push_ok;

    assign push     = |WP_HIT;
    assign EV_VALID = (count != '0);
    assign pop      = EV_VALID & EV_RDY;
    assign full     = (count == FULL_CNT);
    assign push_ok  = push & (~full | pop);
    assign EV_DATA  = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            EV_OVF <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)      count <= count + (PW+1)'(1);
            else if (!push_ok && pop) count <= count - (PW+1)'(1);
            if (push && !push_ok) EV_OVF <= 1'b1;
            else if (OVF_CLR)     EV_OVF <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && push_ok) mem[wr_ptr] <= {WP_HIT, ev_dhit, ev_ihit, ev_addr};
    end
endmodule

// File: tb/tb_lmi_watchu.sv
// Randomised and directed bench for lmi_watchu against a queue-based reference model.
module tb_lmi_watchu;
    localparam int NUM_WP = 4, AW = 32, FIFO_DEPTH = 8, CNT_W = 4;
    localparam int EW = NUM_WP + 2 + AW;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RESET, C_IREAD_I_N, C_DREAD_E, C_DWRITE_E, CP0_XCPN_M, X_HALT, CFG_WE;
    logic [AW-1:0] C_IADDR_A, C_DADDR_E, CFG_ADDR, CFG_MASK;
    logic [3:0] C_DBYEN_E, CFG_MODE, CFG_BYEN;
    logic [2:0] CFG_SEL, CNT_SEL;
    logic BRK_ACK, EV_RDY, OVF_CLR;
    logic [NUM_WP-1:0] WP_HIT;
    logic BRK_REQ, EV_VALID, EV_OVF;
    logic [CNT_W-1:0] CNT_OUT;
    logic [EW-1:0] EV_DATA;

    lmi_watchu #(.NUM_WP(NUM_WP), .AW(AW), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .C_IADDR_A(C_IADDR_A), .C_IREAD_I_N(C_IREAD_I_N),
        .C_DADDR_E(C_DADDR_E), .C_DREAD_E(C_DREAD_E), .C_DWRITE_E(C_DWRITE_E), .C_DBYEN_E(C_DBYEN_E),
        .CP0_XCPN_M(CP0_XCPN_M), .X_HALT(X_HALT), .CFG_WE(CFG_WE), .CFG_SEL(CFG_SEL),
        .CFG_ADDR(CFG_ADDR), .CFG_MASK(CFG_MASK), .CFG_MODE(CFG_MODE), .CFG_BYEN(CFG_BYEN),
        .WP_HIT(WP_HIT), .BRK_REQ(BRK_REQ), .BRK_ACK(BRK_ACK), .CNT_SEL(CNT_SEL), .CNT_OUT(CNT_OUT),
        .EV_VALID(EV_VALID), .EV_DATA(EV_DATA), .EV_RDY(EV_RDY), .EV_OVF(EV_OVF), .OVF_CLR(OVF_CLR)
    );

    int passed = 0, total = 0;

    // Reference model: config table, the access waiting to be compared, outputs of the current cycle.
    logic [AW-1:0] m_addr [NUM_WP];
    logic [AW-1:0] m_mask [NUM_WP];
    logic [3:0]    m_mode [NUM_WP];
    logic [3:0]    m_byen [NUM_WP];
    bit            s_iv, s_dv, s_rd, s_wr;
    logic [AW-1:0] s_ia, s_da;
    logic [3:0]    s_be;
    logic [NUM_WP-1:0] exp_hit;
    logic [EW-1:0] exp_ev;
    bit            exp_brk, exp_ovf;
    int            exp_cnt [NUM_WP];
    logic [EW-1:0] ev_q [$];
    logic [AW-1:0] pool [4];

    function automatic bit amatch(logic [AW-1:0] a, int k);
        return ((a ^ m_addr[k]) & ~m_mask[k]) == '0;
    endfunction

    task automatic cycle();
        logic [NUM_WP-1:0] ih, dh;
        bit bs, dropped;
        if (RESET) begin
            for (int k = 0; k < NUM_WP; k++) begin
                m_addr[k] = '0; m_mask[k] = '0; m_mode[k] = '0; m_byen[k] = '0; exp_cnt[k] = 0;
            end
            s_iv = 0; s_dv = 0; exp_hit = '0; exp_brk = 0; exp_ovf = 0; exp_ev = '0;
            ev_q.delete();
        end else begin
            ih = '0; dh = '0; bs = 0; dropped = 0;
            for (int k = 0; k < NUM_WP; k++) begin
                ih[k] = s_iv && m_mode[k][0] && amatch(s_ia, k);
                dh[k] = s_dv && amatch(s_da, k) && ((s_be & m_byen[k]) != 0)
                        && ((s_rd && m_mode[k][1]) || (s_wr && m_mode[k][2])) && !CP0_XCPN_M;
                if ((ih[k] || dh[k]) && m_mode[k][3]) bs = 1;
            end
            if (ev_q.size() > 0 && EV_RDY) void'(ev_q.pop_front());
            if (|exp_hit) begin
                if (ev_q.size() < FIFO_DEPTH) ev_q.push_back(exp_ev);
                else dropped = 1;
            end
            exp_ovf = dropped ? 1'b1 : (OVF_CLR ? 1'b0 : exp_ovf);
            for (int k = 0; k < NUM_WP; k++) begin
                if (CFG_WE && int'(CFG_SEL) == k) begin
                    exp_cnt[k] = 0;
                    m_addr[k] = CFG_ADDR; m_mask[k] = CFG_MASK; m_mode[k] = CFG_MODE; m_byen[k] = CFG_BYEN;
                end else if (exp_hit[k] && exp_cnt[k] < CMAX) begin
                    exp_cnt[k]++;
                end
            end
            exp_brk = bs || (exp_brk && !BRK_ACK);
            exp_hit = ih | dh;
            exp_ev  = {ih | dh, |dh, |ih, (|dh) ? s_da : s_ia};
            if (X_HALT) begin
                s_iv = 0; s_dv = 0;
            end else begin
                s_iv = !C_IREAD_I_N; s_dv = C_DREAD_E || C_DWRITE_E;
                s_rd = C_DREAD_E; s_wr = C_DWRITE_E;
                s_ia = C_IADDR_A; s_da = C_DADDR_E; s_be = C_DBYEN_E;
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic idle();
        RESET = 0; C_IREAD_I_N = 1; C_DREAD_E = 0; C_DWRITE_E = 0; CP0_XCPN_M = 0; X_HALT = 0;
        CFG_WE = 0; BRK_ACK = 0; OVF_CLR = 0;
    endtask

    task automatic do_reset();
        idle(); RESET = 1; cycle(); RESET = 0;
    endtask

    task automatic cfg_write(int sel, logic [AW-1:0] a, logic [AW-1:0] m, logic [3:0] mode, logic [3:0] be);
        CFG_SEL = 3'(sel); CFG_ADDR = a; CFG_MASK = m; CFG_MODE = mode; CFG_BYEN = be; CFG_WE = 1;
        cycle(); CFG_WE = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (WP_HIT !== '0) $display("FAIL reset_wp_hit got %b exp 0", WP_HIT); else passed++;
        total++; if (BRK_REQ !== 1'b0) $display("FAIL reset_brk got %b exp 0", BRK_REQ); else passed++;
        total++; if (EV_VALID !== 1'b0) $display("FAIL reset_ev_valid got %b exp 0", EV_VALID); else passed++;
        total++; if (EV_OVF !== 1'b0) $display("FAIL reset_ovf got %b exp 0", EV_OVF); else passed++;
        for (int k = 0; k < NUM_WP; k++) begin
            CNT_SEL = 3'(k); #1;
            total++; if (CNT_OUT !== '0) $display("FAIL reset_cnt%0d got %0d exp 0", k, CNT_OUT); else passed++;
        end
    endtask

    task automatic test_ifetch();
        logic [EW-1:0] want;
        do_reset(); EV_RDY = 0; CNT_SEL = 0;
        cfg_write(0, 32'h1000, 32'h00F, 4'b0001, 4'h0);
        C_IADDR_A = 32'h100C; C_IREAD_I_N = 0; cycle(); idle();
        total++; if (WP_HIT !== 4'b0000) $display("FAIL ifetch_early got %b exp 0000", WP_HIT); else passed++;
        cycle();
        total++; if (WP_HIT !== 4'b0001) $display("FAIL ifetch_hit got %b exp 0001", WP_HIT); else passed++;
        cycle();
        want = {4'b0001, 1'b0, 1'b1, 32'h100C};
        total++; if (WP_HIT !== 4'b0000) $display("FAIL ifetch_pulse got %b exp 0000", WP_HIT); else passed++;
        total++; if (EV_VALID !== 1'b1) $display("FAIL ifetch_ev_valid got %b exp 1", EV_VALID); else passed++;
        total++; if (EV_DATA !== want) $display("FAIL ifetch_ev_data got %h exp %h", EV_DATA, want); else passed++;
        total++; if (CNT_OUT !== 4'd1) $display("FAIL ifetch_cnt got %0d exp 1", CNT_OUT); else passed++;
    endtask

    task automatic test_dwrite_brk();
        do_reset(); EV_RDY = 1; CNT_SEL = 1;
        cfg_write(1, 32'h2000, 32'h0, 4'b1100, 4'h3);
        C_DWRITE_E = 1; C_DADDR_E = 32'h2000; C_DBYEN_E = 4'h4; cycle(); idle(); cycle();
        total++; if (WP_HIT !== 4'b0000) $display("FAIL dw_byen_miss got %b exp 0000", WP_HIT); else passed++;
        cycle();
        total++; if (BRK_REQ !== 1'b0) $display("FAIL dw_byen_nobrk got %b exp 0", BRK_REQ); else passed++;
        C_DWRITE_E = 1; C_DBYEN_E = 4'h1; cycle(); idle(); cycle();
        total++; if (WP_HIT !== 4'b0010) $display("FAIL dw_hit got %b exp 0010", WP_HIT); else passed++;
        total++; if (BRK_REQ !== 1'b1) $display("FAIL dw_brk_set got %b exp 1", BRK_REQ); else passed++;
        cycle(); cycle();
        total++; if (BRK_REQ !== 1'b1) $display("FAIL dw_brk_held got %b exp 1", BRK_REQ); else passed++;
        C_DWRITE_E = 1; cycle(); idle(); BRK_ACK = 1; cycle();
        total++; if (BRK_REQ !== 1'b1) $display("FAIL dw_brk_ack_vs_set got %b exp 1", BRK_REQ); else passed++;
        cycle(); BRK_ACK = 0;
        total++; if (BRK_REQ !== 1'b0) $display("FAIL dw_brk_ack got %b exp 0", BRK_REQ); else passed++;
        total++; if (CNT_OUT !== 4'd2) $display("FAIL dw_cnt got %0d exp 2", CNT_OUT); else passed++;
    endtask

    task automatic test_xcpn();
        logic [EW-1:0] want;
        do_reset(); EV_RDY = 0; CNT_SEL = 2;
        cfg_write(2, 32'h3000, 32'h0, 4'b0010, 4'hF);
        C_DREAD_E = 1; C_DADDR_E = 32'h3000; C_DBYEN_E = 4'hF; cycle(); idle(); CP0_XCPN_M = 1; cycle();
        CP0_XCPN_M = 0;
        total++; if (WP_HIT !== 4'b0000) $display("FAIL xcpn_kill got %b exp 0000", WP_HIT); else passed++;
        cycle();
        total++; if (EV_VALID !== 1'b0) $display("FAIL xcpn_nopush got %b exp 0", EV_VALID); else passed++;
        total++; if (CNT_OUT !== 4'd0) $display("FAIL xcpn_cnt got %0d exp 0", CNT_OUT); else passed++;
        C_DREAD_E = 1; cycle(); idle(); cycle();
        total++; if (WP_HIT !== 4'b0100) $display("FAIL dread_hit got %b exp 0100", WP_HIT); else passed++;
        cycle();
        want = {4'b0100, 1'b1, 1'b0, 32'h3000};
        total++; if (EV_DATA !== want) $display("FAIL dread_ev_data got %h exp %h", EV_DATA, want); else passed++;
        total++; if (CNT_OUT !== 4'd1) $display("FAIL dread_cnt got %0d exp 1", CNT_OUT); else passed++;
    endtask

    task automatic test_fifo_ovf();
        logic [EW-1:0] d;
        int n;
        logic [AW-1:0] last;
        do_reset(); EV_RDY = 0;
        cfg_write(0, 32'h1000, 32'h00F, 4'b0001, 4'h0);
        for (int i = 0; i < 9; i++) begin
            C_IADDR_A = 32'h1000 + AW'(i); C_IREAD_I_N = 0; cycle();
        end
        idle(); repeat (3) cycle();
        d = EV_DATA;
        total++; if (EV_OVF !== 1'b1) $display("FAIL ovf_set got %b exp 1", EV_OVF); else passed++;
        total++; if (d[AW-1:0] !== 32'h1000) $display("FAIL ovf_head got %h exp 00001000", d[AW-1:0]); else passed++;
        C_IADDR_A = 32'h100F; C_IREAD_I_N = 0; cycle(); idle(); cycle();
        EV_RDY = 1; cycle(); EV_RDY = 0;
        d = EV_DATA;
        total++; if (d[AW-1:0] !== 32'h1001) $display("FAIL full_pushpop_head got %h exp 00001001", d[AW-1:0]); else passed++;
        OVF_CLR = 1; cycle(); OVF_CLR = 0;
        total++; if (EV_OVF !== 1'b0) $display("FAIL ovf_clr got %b exp 0", EV_OVF); else passed++;
        EV_RDY = 1; n = 0; last = '0;
        while (EV_VALID && n < 20) begin
            d = EV_DATA; last = d[AW-1:0]; n++; cycle();
        end
        EV_RDY = 0;
        total++; if (n !== 8) $display("FAIL full_pushpop_count got %0d exp 8", n); else passed++;
        total++; if (last !== 32'h100F) $display("FAIL full_pushpop_tail got %h exp 0000100f", last); else passed++;
    endtask

    task automatic test_counter_sat();
        do_reset(); EV_RDY = 1; CNT_SEL = 3;
        cfg_write(3, 32'h5000, 32'h0, 4'b0001, 4'h0);
        for (int i = 0; i < 20; i++) begin
            C_IADDR_A = 32'h5000; C_IREAD_I_N = 0; cycle();
        end
        idle(); repeat (3) cycle();
        total++; if (CNT_OUT !== 4'd15) $display("FAIL cnt_sat got %0d exp 15", CNT_OUT); else passed++;
        C_IREAD_I_N = 0; cycle(); idle(); cycle();
        total++; if (WP_HIT[3] !== 1'b1) $display("FAIL cnt_hit_before_clr got %b exp 1", WP_HIT[3]); else passed++;
        cfg_write(3, 32'h5000, 32'h0, 4'b0001, 4'h0);
        total++; if (CNT_OUT !== 4'd0) $display("FAIL cnt_cfg_clr got %0d exp 0", CNT_OUT); else passed++;
    endtask

    task automatic test_halt();
        int bad;
        do_reset(); EV_RDY = 1;
        cfg_write(0, 32'h1000, 32'h00F, 4'b0001, 4'h0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            X_HALT = (i < 4); C_IREAD_I_N = (i < 4) ? 1'b0 : 1'b1; C_IADDR_A = 32'h1004; cycle();
            if (WP_HIT !== 4'b0000) bad++;
        end
        total++; if (bad !== 0) $display("FAIL halt_no_hit got %0d hit cycles exp 0", bad); else passed++;
        idle(); C_IREAD_I_N = 0; cycle(); idle(); X_HALT = 1; C_IREAD_I_N = 0; cycle();
        total++; if (WP_HIT !== 4'b0001) $display("FAIL halt_inflight got %b exp 0001", WP_HIT); else passed++;
        cycle();
        total++; if (WP_HIT !== 4'b0000) $display("FAIL halt_stop got %b exp 0000", WP_HIT); else passed++;
        idle();
    endtask

    task automatic test_reset_fifo();
        do_reset(); EV_RDY = 0; CNT_SEL = 0;
        cfg_write(0, 32'h1000, 32'h00F, 4'b1001, 4'h0);
        for (int i = 0; i < 3; i++) begin
            C_IADDR_A = 32'h1000 + AW'(i); C_IREAD_I_N = 0; cycle();
        end
        idle(); repeat (3) cycle();
        total++; if (EV_VALID !== 1'b1 || BRK_REQ !== 1'b1)
            $display("FAIL rstfifo_pre got valid %b brk %b exp 1 1", EV_VALID, BRK_REQ); else passed++;
        RESET = 1; cycle(); RESET = 0;
        total++; if (EV_VALID !== 1'b0) $display("FAIL rstfifo_valid got %b exp 0", EV_VALID); else passed++;
        total++; if (BRK_REQ !== 1'b0) $display("FAIL rstfifo_brk got %b exp 0", BRK_REQ); else passed++;
        total++; if (CNT_OUT !== 4'd0) $display("FAIL rstfifo_cnt got %0d exp 0", CNT_OUT); else passed++;
        C_IADDR_A = 32'h1000; C_IREAD_I_N = 0; cycle(); idle(); cycle();
        total++; if (WP_HIT !== 4'b0000) $display("FAIL rstfifo_cfg_cleared got %b exp 0000", WP_HIT); else passed++;
    endtask

    task automatic test_random();
        int msel, cs;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            RESET       = ($urandom_range(0, 299) == 0);
            X_HALT      = ($urandom_range(0, 9) == 0);
            C_IREAD_I_N = ($urandom_range(0, 2) == 0);
            C_IADDR_A   = pool[$urandom_range(0, 3)] ^ AW'($urandom_range(0, 15))
                          ^ (($urandom_range(0, 7) == 0) ? AW'(32'h100) : '0);
            C_DADDR_E   = pool[$urandom_range(0, 3)] ^ AW'($urandom_range(0, 15));
            C_DREAD_E   = 1'($urandom_range(0, 1));
            C_DWRITE_E  = 1'($urandom_range(0, 1));
            C_DBYEN_E   = 4'($urandom_range(0, 15));
            CP0_XCPN_M  = ($urandom_range(0, 6) == 0);
            CFG_WE      = ($urandom_range(0, 19) == 0);
            CFG_SEL     = 3'($urandom_range(0, 7));
            CFG_ADDR    = pool[$urandom_range(0, 3)];
            msel        = $urandom_range(0, 3);
            CFG_MASK    = (msel == 0) ? '0 : (msel == 1) ? 32'hF : (msel == 2) ? 32'h10F : AW'($urandom);
            CFG_MODE    = 4'($urandom_range(0, 15));
            CFG_BYEN    = 4'($urandom_range(0, 15));
            BRK_ACK     = ($urandom_range(0, 3) == 0);
            EV_RDY      = ((n % 200) < 120) ? 1'($urandom_range(0, 1)) : 1'b0;
            OVF_CLR     = ($urandom_range(0, 9) == 0);
            CNT_SEL     = 3'($urandom_range(0, NUM_WP - 1));
            cycle();
            cs = int'(CNT_SEL);
            total++; if (WP_HIT !== exp_hit) $display("FAIL rand_wp_hit @%0d got %b exp %b", n, WP_HIT, exp_hit); else passed++;
            total++; if (BRK_REQ !== exp_brk) $display("FAIL rand_brk @%0d got %b exp %b", n, BRK_REQ, exp_brk); else passed++;
            total++; if (EV_OVF !== exp_ovf) $display("FAIL rand_ovf @%0d got %b exp %b", n, EV_OVF, exp_ovf); else passed++;
            total++; if (EV_VALID !== (ev_q.size() != 0))
                $display("FAIL rand_ev_valid @%0d got %b exp %b", n, EV_VALID, ev_q.size() != 0); else passed++;
            if (ev_q.size() != 0) begin
                total++; if (EV_DATA !== ev_q[0]) $display("FAIL rand_ev_data @%0d got %h exp %h", n, EV_DATA, ev_q[0]); else passed++;
            end
            total++; if (CNT_OUT !== CNT_W'(exp_cnt[cs]))
                $display("FAIL rand_cnt @%0d got %0d exp %0d", n, CNT_OUT, exp_cnt[cs]); else passed++;
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        pool[0] = 32'h0000_1000; pool[1] = 32'h0000_2000; pool[2] = 32'h0008_0040; pool[3] = 32'hFFFF_FFF0;
        idle();
        C_IADDR_A = '0; C_DADDR_E = '0; C_DBYEN_E = '0; CFG_SEL = '0; CFG_ADDR = '0; CFG_MASK = '0;
        CFG_MODE = '0; CFG_BYEN = '0; CNT_SEL = '0; EV_RDY = 0;
        test_reset();
        test_ifetch();
        test_dwrite_brk();
        test_xcpn();
        test_fifo_ovf();
        test_counter_sat();
        test_halt();
        test_reset_fifo();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
